id_stage: RTL

//  RV32I decode stage of the 5-stage pipeline, directly downstream of instruction fetch.

---
 rtl/id_stage_if.sv | 46 ++++
 rtl/id_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// Interface bundling the fetch, regfile, bypass, hazard and EX-side signals of
// the RV32I decode stage. The slave modport is the decode stage's view, and the
// master modport is the view of the surrounding pipeline or testbench.
interface id_stage_if #(
  parameter int XLEN  = 32,
  parameter int REGAW = 5
);
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_instr;
  logic             in_valid;
  logic             in_ready;
  logic [REGAW-1:0] rf_ra1;
  logic [REGAW-1:0] rf_ra2;
  logic [XLEN-1:0]  rf_rd1;
  logic [XLEN-1:0]  rf_rd2;
  logic             wb_we;
  logic [REGAW-1:0] wb_rd;
  logic [XLEN-1:0]  wb_wdata;
  logic             ex_memread;
  logic [REGAW-1:0] ex_rd;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_imm;
  logic [XLEN-1:0]  out_rs1v;
  logic [XLEN-1:0]  out_rs2v;
  logic [REGAW-1:0] out_rd;
  logic [3:0]       out_aluop;
  logic [9:0]       out_ctrl;
  logic [2:0]       out_funct3;

  modport slave (
    input  in_pc, in_instr, in_valid, rf_rd1, rf_rd2, wb_we, wb_rd, wb_wdata,
           ex_memread, ex_rd, flush, out_ready,
    output in_ready, rf_ra1, rf_ra2, out_valid, out_pc, out_imm, out_rs1v,
           out_rs2v, out_rd, out_aluop, out_ctrl, out_funct3
  );

  modport master (
    output in_pc, in_instr, in_valid, rf_rd1, rf_rd2, wb_we, wb_rd, wb_wdata,
           ex_memread, ex_rd, flush, out_ready,
    input  in_ready, rf_ra1, rf_ra2, out_valid, out_pc, out_imm, out_rs1v,
           out_rs2v, out_rd, out_aluop, out_ctrl, out_funct3
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetch bundle, reads operands (with a
// writeback bypass), builds the immediate and control word, and registers one
// bundle toward EX behind a valid/ready handshake. A flush from EX kills both
// the held bundle and the one being offered.
// Optional feature macro: ID_LOAD_USE_STALL_EN enables a load-use stall that
// holds off fetch and inserts a bubble while the EX instruction is a load
// whose rd feeds this instruction.
// out_ctrl = {asel_pc,bsel_imm,memrd,memwr,regwr,branch,jal,jalr,illegal,funct3_vld}
module id_stage #(
  parameter int XLEN  = 32,
  parameter int REGAW = 5
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [REGAW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]  rs1v, rs2v, imm_d;
  logic [3:0]       aluop_d;
  logic             asel_pc, bsel_imm, memrd, memwr, regwr_base, regwr;
  logic             branch, jal, jalr, illegal, f3_vld;
  logic [REGAW-1:0] rd_d;
  logic             stall, in_ready, accept;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_pc_q, out_imm_q, out_rs1v_q, out_rs2v_q;
  logic [REGAW-1:0] out_rd_q;
  logic [3:0]       out_aluop_q;
  logic [9:0]       out_ctrl_q;
  logic [2:0]       out_funct3_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[15 +: REGAW];
  assign rs2    = instr[20 +: REGAW];
  assign rd     = instr[7 +: REGAW];

  assign bus.rf_ra1 = rs1;
  assign bus.rf_ra2 = rs2;

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

  // Operand select: x0 reads as zero, otherwise writeback data bypasses the regfile.
  always_comb begin
    rs1v = bus.rf_rd1;
    rs2v = bus.rf_rd2;
    if (rs1 == '0)                               rs1v = '0;
    else if (bus.wb_we && (bus.wb_rd == rs1))    rs1v = bus.wb_wdata;
    if (rs2 == '0)                               rs2v = '0;
    else if (bus.wb_we && (bus.wb_rd == rs2))    rs2v = bus.wb_wdata;
  end

  // Opcode decode into ALU op, immediate and control flags.
  always_comb begin
    aluop_d    = ALU_ADD;
    imm_d      = imm_i;
    asel_pc    = 1'b0;
    bsel_imm   = 1'b0;
    memrd      = 1'b0;
    memwr      = 1'b0;
    regwr_base = 1'b0;
    branch     = 1'b0;
    jal        = 1'b0;
    jalr       = 1'b0;
    illegal    = 1'b0;
    f3_vld     = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LUI:    begin aluop_d = ALU_PASSB; imm_d = imm_u; bsel_imm = 1'b1; regwr_base = 1'b1; end
        OP_AUIPC:  begin imm_d = imm_u; asel_pc = 1'b1; bsel_imm = 1'b1; regwr_base = 1'b1; end
        OP_JAL:    begin imm_d = imm_j; jal = 1'b1; asel_pc = 1'b1; bsel_imm = 1'b1; regwr_base = 1'b1; end
        OP_JALR:   begin jalr = 1'b1; bsel_imm = 1'b1; regwr_base = 1'b1; end
        OP_BRANCH: begin aluop_d = ALU_SUB; imm_d = imm_b; branch = 1'b1; f3_vld = 1'b1; end
        OP_LOAD:   begin memrd = 1'b1; bsel_imm = 1'b1; regwr_base = 1'b1; f3_vld = 1'b1; end
        OP_STORE:  begin imm_d = imm_s; memwr = 1'b1; bsel_imm = 1'b1; f3_vld = 1'b1; end
        OP_IMM, OP_OP: begin
          bsel_imm   = (opcode == OP_IMM);
          regwr_base = 1'b1;
          case (funct3)
            3'd0:    aluop_d = ((opcode == OP_OP) && instr[30]) ? ALU_SUB : ALU_ADD;
            3'd1:    aluop_d = ALU_SLL;
            3'd2:    aluop_d = ALU_SLT;
            3'd3:    aluop_d = ALU_SLTU;
            3'd4:    aluop_d = ALU_XOR;
            3'd5:    aluop_d = instr[30] ? ALU_SRA : ALU_SRL;
            3'd6:    aluop_d = ALU_OR;
            default: aluop_d = ALU_AND;
          endcase
        end
        OP_FENCE, OP_SYSTEM: ;
        default:   illegal = 1'b1;
      endcase
    end
  end

  assign regwr = regwr_base & (rd != '0);
  assign rd_d  = regwr ? rd : '0;

`ifdef ID_LOAD_USE_STALL_EN
  assign stall = bus.in_valid & bus.ex_memread & (bus.ex_rd != '0) &
                 ((bus.ex_rd == rs1) | (bus.ex_rd == rs2));
`else
  logic unused_ex;
  assign unused_ex = ^{bus.ex_memread, bus.ex_rd};
  assign stall     = 1'b0;
`endif

  assign in_ready     = (~out_valid_q | bus.out_ready) & ~stall & ~rst & ~bus.flush;
  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;

  // Output register: flush drops the held bundle, accept loads, drain clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_imm_q    <= '0;
      out_rs1v_q   <= '0;
      out_rs2v_q   <= '0;
      out_rd_q     <= '0;
      out_aluop_q  <= '0;
      out_ctrl_q   <= '0;
      out_funct3_q <= '0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_pc_q     <= bus.in_pc;
      out_imm_q    <= imm_d;
      out_rs1v_q   <= rs1v;
      out_rs2v_q   <= rs2v;
      out_rd_q     <= rd_d;
      out_aluop_q  <= aluop_d;
      out_ctrl_q   <= {asel_pc, bsel_imm, memrd, memwr, regwr, branch, jal, jalr, illegal, f3_vld};
      out_funct3_q <= funct3;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.out_imm    = out_imm_q;
  assign bus.out_rs1v   = out_rs1v_q;
  assign bus.out_rs2v   = out_rs2v_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.out_aluop  = out_aluop_q;
  assign bus.out_ctrl   = out_ctrl_q;
  assign bus.out_funct3 = out_funct3_q;
endmodule
